data_sram_responder: RTL and testbench

//   Memory-side responder for the CPU data port. Accepts one load or store

---
 rtl/data_sram_responder.sv | 119 +++++++++++
 tb/tb_data_sram_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Data-port memory responder: one outstanding load/store, answered after a
// fixed programmable latency with byte-masked stores and full-word loads.
module data_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_wdata,
  output logic        o_addr_ok,
  output logic        o_data_ok,
  output logic [31:0] o_rdata
);

  // state | meaning
  // IDLE  | ready, addr_ok=1, accepts a request
  // BUSY  | latency countdown, requests ignored
  // RESP  | final latency cycle, memory access at its closing edge
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t              r_state;
  state_t              w_next;
  logic   [3:0]        r_cnt;
  logic   [3:0]        w_cnt_next;
  logic                r_wr;
  logic   [ADDR_W-1:0] r_idx;
  logic   [3:0]        r_wstrb;
  logic   [31:0]       r_wdata;
  logic                r_data_ok;
  logic   [31:0]       r_rdata;
  logic   [31:0]       r_mem [0:(2**ADDR_W)-1];
  logic                w_accept;
  logic                w_do_access;
  logic   [ADDR_W-1:0] w_idx;
  logic   [31-ADDR_W:0] w_unused_addr;

  assign w_idx         = i_addr[ADDR_W+1:2];
  assign w_unused_addr = {i_addr[31:ADDR_W+2], i_addr[1:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // The counter reaches zero on the RESP cycle, so data_ok lands LATENCY+1
  // cycles after the accept cycle and the FSM is back in IDLE with it.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_cnt_next = LAT_M1;
          w_next     = (LATENCY == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_next = S_RESP;
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = 4'd0;
      end
    endcase
  end

  always_comb begin
    o_addr_ok   = (r_state == S_IDLE) && !i_rst;
    w_accept    = o_addr_ok && i_req;
    w_do_access = (r_state == S_RESP) && !i_rst;
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_wr    <= i_wr;
      r_idx   <= w_idx;
      r_wstrb <= i_wstrb;
      r_wdata <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data_ok <= 1'b0;
      r_rdata   <= 32'h0;
    end else begin
      r_data_ok <= w_do_access;
      if (w_do_access && !r_wr) r_rdata <= r_mem[r_idx];
    end
  end

  // Memory has no reset; contents survive rst.
  always_ff @(posedge i_clk) begin
    if (w_do_access && r_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wstrb[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign o_data_ok = r_data_ok;
  assign o_rdata   = r_rdata;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: timestamp/array reference model checked
// every cycle, directed scenarios with literal results, random traffic.
module tb_data_sram_responder;

  localparam int LAT = 2;
  localparam int AW  = 10;

  logic        clk = 1'b0;
  logic        rst, req, wr;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        aok, dok;
  logic [31:0] rdata;

  logic [1:0]  treq;
  logic [1:0]  taok, tdok;
  logic [31:0] trd0, trd1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(AW), .LATENCY(LAT)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_wr(wr), .i_addr(addr),
    .i_wstrb(wstrb), .i_wdata(wdata),
    .o_addr_ok(aok), .o_data_ok(dok), .o_rdata(rdata)
  );

  data_sram_responder #(.ADDR_W(4), .LATENCY(1)) u_l1 (
    .i_clk(clk), .i_rst(rst), .i_req(treq[0]), .i_wr(1'b1), .i_addr(32'h0),
    .i_wstrb(4'h0), .i_wdata(32'h0),
    .o_addr_ok(taok[0]), .o_data_ok(tdok[0]), .o_rdata(trd0)
  );

  data_sram_responder #(.ADDR_W(4), .LATENCY(4)) u_l4 (
    .i_clk(clk), .i_rst(rst), .i_req(treq[1]), .i_wr(1'b1), .i_addr(32'h0),
    .i_wstrb(4'h0), .i_wdata(32'h0),
    .o_addr_ok(taok[1]), .o_data_ok(tdok[1]), .o_rdata(trd1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: one outstanding request with a due cycle, word array.
  int          cyc = 0;
  bit          m_init = 0;
  bit          m_busy = 0;
  bit          m_dok = 0;
  int          m_due;
  bit          m_wr;
  int          m_idx;
  logic [3:0]  m_strb;
  logic [31:0] m_wd;
  logic [31:0] m_rdata = 32'h0;
  logic [31:0] m_mem [1024];

  always @(posedge clk) begin
    m_dok = 0;
    if (rst) begin
      m_init  = 1;
      m_busy  = 0;
      m_rdata = 32'h0;
    end else if (m_busy) begin
      if (cyc == m_due) begin
        if (m_wr) begin
          for (int i = 0; i < 4; i++)
            if (m_strb[i]) m_mem[m_idx][8*i +: 8] = m_wd[8*i +: 8];
        end else begin
          m_rdata = m_mem[m_idx];
        end
        m_dok  = 1;
        m_busy = 0;
      end
    end else if (req) begin
      m_busy = 1;
      m_due  = cyc + LAT;
      m_wr   = wr;
      m_idx  = int'((addr >> 2) % 32'd1024);
      m_strb = wstrb;
      m_wd   = wdata;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("addr_ok", 32'(aok), 32'(!rst && !m_busy));
      chk("data_ok", 32'(dok), 32'(m_dok));
      chk("rdata", rdata, m_rdata);
    end
  end

  task automatic wait_accept(output int acc);
    acc = -1;
    for (int k = 0; k < 30 && acc < 0; k++) begin
      @(negedge clk);
      if (aok) acc = cyc;
      else begin @(posedge clk); #2; end
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=none required=addr_ok");
    end
  endtask

  task automatic xact(input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] rd);
    int acc;
    bit got;
    rd = 32'h0;
    got = 0;
    req = 1; wr = w; addr = a; wstrb = s; wdata = d;
    wait_accept(acc);
    if (acc < 0) begin req = 0; return; end
    @(posedge clk); #2;
    req = 0; wr = 1'($urandom); addr = $urandom; wstrb = 4'($urandom); wdata = $urandom;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (dok) begin
        got = 1;
        rd  = rdata;
        chk("latency", 32'(cyc - acc), 32'(LAT + 1));
      end else begin
        @(posedge clk); #2;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL data_ok_timeout actual=none required=pulse");
    end
    @(posedge clk); #2;
  endtask

  task automatic tcheck(input int which, input int lat);
    int acc;
    acc = -1;
    treq[which] = 1'b1;
    for (int k = 0; k < 10 && acc < 0; k++) begin
      @(negedge clk);
      if (taok[which]) acc = cyc;
      else begin @(posedge clk); #2; end
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL t_accept_timeout actual=none required=addr_ok lat=%0d", lat);
      treq[which] = 1'b0;
      return;
    end
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge clk); #2;
      @(negedge clk);
      if (k <= lat) begin
        chk("t_addr_ok_busy", 32'(taok[which]), 32'h0);
        chk("t_dok_early", 32'(tdok[which]), 32'h0);
      end else begin
        chk("t_dok", 32'(tdok[which]), 32'h1);
        chk("t_addr_ok_done", 32'(taok[which]), 32'h1);
        treq[which] = 1'b0;
      end
    end
    @(posedge clk); #2;
    @(negedge clk);
    chk("t_dok_single", 32'(tdok[which]), 32'h0);
    @(posedge clk); #2;
  endtask

  initial begin
    logic [31:0] rd, r, a;
    int n, idx;
    rst = 1; req = 0; wr = 0; addr = 0; wstrb = 0; wdata = 0; treq = 2'b00;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_addr_ok", 32'(aok), 32'h1);
    @(posedge clk); #2;

    for (int i = 0; i < 16; i++) xact(1'b1, 32'(i * 4), 4'hF, 32'h0, rd);

    // basic word store/load and partial-lane stores
    xact(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, rd);
    xact(1'b0, 32'h10, 4'b0000, 32'h0, rd);
    chk("sw_lw", rd, 32'hDEADBEEF);
    xact(1'b1, 32'h11, 4'b0010, 32'h55555555, rd);
    xact(1'b0, 32'h10, 4'b1010, 32'h0, rd);
    chk("sb", rd, 32'hDEAD55EF);
    xact(1'b1, 32'h12, 4'b1100, 32'h12341234, rd);
    xact(1'b0, 32'h10, 4'b0000, 32'h0, rd);
    chk("sh", rd, 32'h123455EF);

    // zero-strobe store leaves memory alone
    xact(1'b1, 32'h20, 4'b1111, 32'hA5A5A5A5, rd);
    xact(1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, rd);
    xact(1'b0, 32'h20, 4'b0000, 32'h0, rd);
    chk("zero_strobe", rd, 32'hA5A5A5A5);

    // reset while busy aborts the store
    req = 1; wr = 1; addr = 32'h30; wstrb = 4'hF; wdata = 32'hFFFFFFFF;
    wait_accept(n);
    @(posedge clk); #2;
    req = 0; rst = 1;
    @(posedge clk); #2;
    rst = 0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (dok) n++;
      @(posedge clk); #2;
    end
    chk("abort_no_dok", 32'(n), 32'h0);
    @(negedge clk);
    chk("abort_rdata", rdata, 32'h0);
    @(posedge clk); #2;
    xact(1'b0, 32'h30, 4'hF, 32'h0, rd);
    chk("abort_no_write", rd, 32'h0);

    // address aliasing
    xact(1'b1, 32'h1004, 4'hF, 32'hCAFEF00D, rd);
    xact(1'b0, 32'h0004, 4'h0, 32'h0, rd);
    chk("alias", rd, 32'hCAFEF00D);

    // back-to-back loads with req held high
    req = 1; wr = 0; addr = 32'h10; wstrb = 4'h0;
    wait_accept(idx);
    n = 1;
    @(posedge clk); #2;
    repeat (11) begin
      @(negedge clk);
      if (aok) n++;
      @(posedge clk); #2;
    end
    req = 0;
    chk("b2b_accepts", 32'(n), 32'h4);
    repeat (5) @(posedge clk);
    #2;

    tcheck(0, 1);
    tcheck(1, 4);
    chk("t_rdata_l1", trd0, 32'h0);
    chk("t_rdata_l4", trd1, 32'h0);

    for (int t = 0; t < 80; t++) begin
      n = $urandom_range(0, 2);
      repeat (n) begin @(posedge clk); #2; end
      idx = $urandom_range(0, 15);
      r = $urandom;
      a = (r & 32'hFFFFF003) | (32'(idx) << 2);
      xact(1'($urandom), a, 4'($urandom), $urandom, rd);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
